math_addsub_accum: RTL and testbench
====================================

# math_addsub_accum

Sequential accumulate stage that takes a stream of operands and adds or subtracts each one into an N-bit running total. The arithmetic matches the N-bit ripple add/sub datapath: on subtract, b is inverted and carry-in is 1. When a packet ends, the block presents the total together with the carry-out and sticky unsigned and signed overflow flags. It sits between an operand source using a valid/ready stream and a result consumer, and adds packet framing, backpressure and overflow accounting around the combinational add/sub.

## Interface
- N, default 8: operand and accumulator width, must be ≥ 2.
- CNT_W, default 8: width of the operand counter.

- i_clk, input, 1: clock. All state updates on the rising edge.
- i_rst_n, input, 1: reset, asynchronous and active-low.
- i_clear, input, 1: synchronous abort. Returns to IDLE and discards the packet.
- i_valid, input, 1: an operand beat is present.
- o_ready, output, 1: the block can accept a beat.
- i_data, input, N: the operand.
- i_sub, input, 1: 0 adds the operand, 1 subtracts it from the accumulator.
- i_last, input, 1: this beat closes the packet.
- o_valid, output, 1: the result is presented.
- i_ready, input, 1: the consumer accepts the result.
- o_result, output, N: the accumulated total.
- o_carry, output, 1: raw carry-out of the last beat's add/sub.
- o_ovf_u, output, 1: sticky unsigned overflow or borrow within the packet.
- o_ovf_s, output, 1: sticky two's-complement overflow within the packet.
- o_count, output, CNT_W: beats accepted in the packet. Saturates at all-ones.

## Operation
- A beat is accepted in any cycle where i_valid and o_ready are both high.
- States:
  - IDLE: accumulator is 0 and o_ready = 1.
  - ACCUM: o_ready = 1.
  - DONE: o_ready = 0 and o_valid = 1.
- Transitions:
  - IDLE, beat accepted with i_last = 0 → ACCUM.
  - IDLE or ACCUM, beat accepted with i_last = 1 → DONE.
  - DONE with i_ready = 1 → IDLE. The accumulator, count and flags clear on the same edge.
  - i_clear = 1 → IDLE from any state. It has priority over a beat or a result accept in the same cycle. A result held in DONE is discarded.
- Arithmetic per beat:
  - b' = i_data XOR {N{i_sub}}.
  - {c, s} = acc + b' + i_sub.
  - acc ← s and o_carry ← c.
  - The first beat of a packet uses acc = 0. A single subtract beat therefore yields −i_data.
- Unsigned flag:
  - On add, set if c = 1.
  - On subtract, set if c = 0 (borrow).
- Signed flag: set if acc[N-1] == b'[N-1] and s[N-1] != acc[N-1].
- Both flags are sticky: they OR across all beats and clear only on a return to IDLE.
- o_count increments on every accepted beat and holds at 2^CNT_W − 1.
- o_result, o_carry, o_ovf_u, o_ovf_s and o_count are registered. They are valid whenever o_valid = 1 and hold stable in DONE until the result is accepted.

## Timing
- Reset values:
  - State is IDLE.
  - o_valid = 0 and o_ready = 1.
  - o_result, o_carry, o_ovf_u, o_ovf_s and o_count are all 0.
- Inputs are ignored while i_rst_n is low.
- Reset asserted mid-packet or in DONE discards everything immediately and asynchronously.
- Throughput is one beat per cycle in IDLE and ACCUM.
- Latency: o_valid rises in the cycle after the i_last beat is accepted.
- After a packet there is at least one bubble, because o_ready is low in DONE. The earliest next beat is accepted in the cycle after the result handshake.
- o_valid stays high for as long as i_ready stays low, with no timeout.
- i_valid while o_ready = 0 is ignored and no beat is consumed. The source must hold the beat.
- No combinational path from i_valid or i_data to any output. o_ready depends only on state.

## Test plan
- N = 8. Beats add 10, add 20, add 30 (last) → o_result = 60, o_count = 3, o_ovf_u = 0, o_ovf_s = 0, o_carry = 0.
- Beats add 5, sub 7 (last) → o_result = 0xFE, o_carry = 0, o_ovf_u = 1 (borrow), o_ovf_s = 0.
- Beats add 100, add 100 (last) → o_result = 0xC8, o_ovf_s = 1, o_ovf_u = 0.
- Beats add 200, add 100 (last) → o_result = 0x2C, o_carry = 1, o_ovf_u = 1, o_ovf_s = 0.
- Backpressure: hold i_ready = 0 for 5 cycles after the last beat → o_valid stays 1 and all outputs stay stable. o_ready = 0 throughout and an offered beat is not consumed. The first new beat is accepted the cycle after i_ready = 1.
- Abort cases:
  - i_clear in ACCUM with 3 beats accumulated → next cycle is IDLE with o_count = 0 and flags 0.
  - i_rst_n pulsed low in DONE → o_valid drops immediately and all outputs read 0.
  - After either abort, a fresh packet of add 1 (last) → o_result = 1.

Source files
------------

// File: rtl/math_addsub_accum.sv
// Packet accumulator around an N-bit ripple add/sub datapath.
// Presents the running total with carry and sticky overflow flags at packet end.
module math_addsub_accum #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    input  logic             i_sub,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_result,
    output logic             o_carry,
    output logic             o_ovf_u,
    output logic             o_ovf_s,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_u_q, ovf_u_d;
    logic             ovf_s_q, ovf_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic [N-1:0]     acc_base;
    logic             ovf_u_base;
    logic             ovf_s_base;
    logic [CNT_W-1:0] cnt_base;
    logic [N-1:0]     b_x;
    logic [N:0]       sum;
    logic             beat;

    // Add/sub datapath; a packet's first beat starts from a zero accumulator
    always_comb begin
        acc_base   = (state_q == S_IDLE) ? '0 : acc_q;
        ovf_u_base = (state_q == S_IDLE) ? 1'b0 : ovf_u_q;
        ovf_s_base = (state_q == S_IDLE) ? 1'b0 : ovf_s_q;
        cnt_base   = (state_q == S_IDLE) ? '0 : cnt_q;
        b_x        = i_data ^ {N{i_sub}};
        sum        = {1'b0, acc_base} + {1'b0, b_x} + (N+1)'(i_sub);
        beat       = i_valid && ready_q;
    end

    // Next-state and next-output logic; clear overrides beats and result accepts
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_u_d = ovf_u_q;
        ovf_s_d = ovf_s_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ready_d = ready_q;
        if (i_clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            carry_d = 1'b0;
            ovf_u_d = 1'b0;
            ovf_s_d = 1'b0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ready_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (beat) begin
                        acc_d   = sum[N-1:0];
                        carry_d = sum[N];
                        ovf_u_d = ovf_u_base | (i_sub ? ~sum[N] : sum[N]);
                        ovf_s_d = ovf_s_base
                                | ((acc_base[N-1] == b_x[N-1])
                                && (sum[N-1] != acc_base[N-1]));
                        cnt_d   = (cnt_base == CNT_MAX) ? CNT_MAX
                                : cnt_base + CNT_W'(1);
                        state_d = i_last ? S_DONE : S_ACCUM;
                        valid_d = i_last;
                        ready_d = ~i_last;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        carry_d = 1'b0;
                        ovf_u_d = 1'b0;
                        ovf_s_d = 1'b0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_u_d = 1'b0;
                    ovf_s_d = 1'b0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_u_q <= 1'b0;
            ovf_s_q <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_u_q <= ovf_u_d;
            ovf_s_q <= ovf_s_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = acc_q;
    assign o_carry  = carry_q;
    assign o_ovf_u  = ovf_u_q;
    assign o_ovf_s  = ovf_s_q;
    assign o_count  = cnt_q;

endmodule

// File: tb/tb_math_addsub_accum.sv
// Scoreboard bench for math_addsub_accum.
// Expected packet results are queued at drive time and popped at result time.
module tb_math_addsub_accum;

    localparam int N     = 8;
    localparam int CNT_W = 8;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_clear;
    logic             i_valid;
    logic             o_ready;
    logic [N-1:0]     i_data;
    logic             i_sub;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic [N-1:0]     o_result;
    logic             o_carry;
    logic             o_ovf_u;
    logic             o_ovf_s;
    logic [CNT_W-1:0] o_count;

    math_addsub_accum #(.N(N), .CNT_W(CNT_W)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (i_clear),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_sub    (i_sub),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_carry  (o_carry),
        .o_ovf_u  (o_ovf_u),
        .o_ovf_s  (o_ovf_s),
        .o_count  (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       u;
        logic       s;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_acc;
    logic       m_c;
    logic       m_u;
    logic       m_s;
    logic [7:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_clr();
        m_acc = '0;
        m_c   = 1'b0;
        m_u   = 1'b0;
        m_s   = 1'b0;
        m_cnt = '0;
    endtask

    // Reference: plain integer arithmetic, independent of the gate datapath
    task automatic mdl_beat(input logic [7:0] d, input logic sub,
                            input logic last);
        int ua, ud, sa, sd, r;
        exp_t e;
        ua = int'(m_acc);
        ud = int'(d);
        sa = int'($signed(m_acc));
        sd = int'($signed(d));
        if (sub) begin
            m_c = (ua >= ud);
            m_u = m_u | !m_c;
            r   = sa - sd;
            m_acc = m_acc - d;
        end else begin
            m_c = (ua + ud) > 255;
            m_u = m_u | m_c;
            r   = sa + sd;
            m_acc = m_acc + d;
        end
        if (r > 127 || r < -128) m_s = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (last) begin
            e.res = m_acc;
            e.c   = m_c;
            e.u   = m_u;
            e.s   = m_s;
            e.cnt = m_cnt;
            sb.push_back(e);
            mdl_clr();
        end
    endtask

    // Called at a negedge; beat is taken on the next posedge
    task automatic drive(input logic [7:0] d, input logic sub,
                         input logic last);
        i_valid = 1'b1;
        i_data  = d;
        i_sub   = sub;
        i_last  = last;
        mdl_beat(d, sub, last);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_res"}, o_result, 0);
        chk({tag, "_flags"}, {o_carry, o_ovf_u, o_ovf_s}, 0);
        chk({tag, "_cnt"}, o_count, 0);
    endtask

    // Called right after the last beat; holds i_ready low for hold cycles
    task automatic take_result(input string tag, input int hold);
        exp_t e;
        int k;
        k = 0;
        chk({tag, "_lat"}, o_valid, 1);
        while (!o_valid && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_valid"}, o_valid, 1);
            chk({tag, "_ready"}, o_ready, 0);
            chk({tag, "_res"}, o_result, e.res);
            chk({tag, "_carry"}, o_carry, e.c);
            chk({tag, "_ovf_u"}, o_ovf_u, e.u);
            chk({tag, "_ovf_s"}, o_ovf_s, e.s);
            chk({tag, "_cnt"}, o_count, e.cnt);
            if (h < hold) @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk({tag, "_drop"}, o_valid, 0);
        chk({tag, "_clr_cnt"}, o_count, 0);
    endtask

    initial begin
        exp_t e;
        i_rst_n = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_sub   = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        mdl_clr();
        repeat (3) @(negedge i_clk);
        check_zero("rst");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_zero("idle");

        drive(8'd10, 1'b0, 1'b0);
        drive(8'd20, 1'b0, 1'b0);
        drive(8'd30, 1'b0, 1'b1);
        take_result("p60", 0);

        drive(8'd5, 1'b0, 1'b0);
        drive(8'd7, 1'b1, 1'b1);
        take_result("borrow", 0);

        drive(8'd100, 1'b0, 1'b0);
        drive(8'd100, 1'b0, 1'b1);
        take_result("sovf", 0);

        drive(8'd200, 1'b0, 1'b0);
        drive(8'd100, 1'b0, 1'b1);
        take_result("uovf", 0);

        // Backpressure with a beat offered while DONE
        drive(8'd3, 1'b0, 1'b0);
        drive(8'd4, 1'b0, 1'b1);
        e = sb.pop_front();
        i_valid = 1'b1;
        i_data  = 8'd9;
        i_sub   = 1'b0;
        i_last  = 1'b1;
        for (int h = 0; h < 5; h++) begin
            chk("bp_valid", o_valid, 1);
            chk("bp_ready", o_ready, 0);
            chk("bp_res", o_result, e.res);
            chk("bp_cnt", o_count, e.cnt);
            chk("bp_flags", {o_carry, o_ovf_u, o_ovf_s}, {e.c, e.u, e.s});
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("bp_hs_valid", o_valid, 0);
        chk("bp_hs_ready", o_ready, 1);
        mdl_beat(8'd9, 1'b0, 1'b1);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        take_result("bp_next", 0);

        // Clear in ACCUM, with a beat offered in the same cycle
        drive(8'd200, 1'b0, 1'b0);
        drive(8'd100, 1'b0, 1'b0);
        drive(8'd50, 1'b1, 1'b0);
        chk("acc_cnt", o_count, 3);
        chk("acc_ovf_u", o_ovf_u, 1);
        mdl_clr();
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'd1;
        @(negedge i_clk);
        i_clear = 1'b0;
        i_valid = 1'b0;
        check_zero("clr");
        drive(8'd1, 1'b0, 1'b1);
        take_result("clr_p1", 0);

        // Async reset while DONE
        drive(8'd77, 1'b0, 1'b1);
        chk("rst_done_valid", o_valid, 1);
        void'(sb.pop_front());
        #2 i_rst_n = 1'b0;
        #1 check_zero("async");
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        drive(8'd1, 1'b0, 1'b1);
        take_result("rst_p1", 0);

        // Count saturation over a long packet
        for (int i = 0; i < 259; i++) drive(8'd1, 1'b0, 1'b0);
        drive(8'd1, 1'b0, 1'b1);
        take_result("sat", 1);

        // Random packets with random hold-off
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                drive(8'($urandom), 1'($urandom), b == len - 1);
            take_result("rnd", $urandom_range(0, 3));
        end

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
